// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit.
package ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SEL_W    = 2;

    // Controller states; the numeric values are exported on the debug port.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    // Major opcodes (instruction[6:0]).
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 7'b1100011;

    // ALU operand A select.
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_REGA  = 2'b10;

    // ALU operand B select.
    localparam logic [SEL_W-1:0] SRCB_REGB  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    // Writeback / PC-next result select.
    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

    // ALU operation class handed to the ALU decoder.
    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore controller sequencing fetch/decode/execute/memory/writeback for a
// multicycle RISC-V datapath, with a memory-ready stall and a sticky trap.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter bit ENABLE_ITYPE = 1'b1,
    parameter bit ENABLE_JAL   = 1'b1,
    parameter bit MEM_WAIT     = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write,
    output logic                ir_write,
    output logic                adr_src,
    output logic                pc_write,
    output logic                reg_write,
    output logic [SEL_W-1:0]    alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [SEL_W-1:0]    result_src,
    output logic [SEL_W-1:0]    alu_op,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    state_e state_q;
    state_e state_d;
    logic   ready;

    // Without the wait handshake every access completes in one cycle.
    assign ready = MEM_WAIT ? mem_ready : 1'b1;
    assign state = state_q;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REGB;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 computed in the ALU and written straight back to PC.
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                // Write enables held low while reset is asserted.
                ir_write   = ready & ~reset;
                pc_write   = ready & ~reset;
                if (ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target: old PC + immediate.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = ENABLE_ITYPE ? S_EXECI : S_TRAP;
                    OP_JAL:            state_d = ENABLE_JAL ? S_JAL : S_TRAP;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_REGB;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // Jump to the target latched in DECODE; link computed as old PC + 4.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_REGB;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: three configurations side by side
// (all paths enabled, JAL/I-type disabled, no memory wait).
module tb_multicycle_control;

    localparam int unsigned VW = 19;

    logic           clk;
    logic           zero;
    logic           rst [3];
    logic [6:0]     op  [3];
    logic           rdy [3];
    logic [VW-1:0]  obs [3];

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       mem_req, mem_write, ir_write, adr_src, pc_write, reg_write, illegal;
        logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
        logic [3:0] state;

        multicycle_control #(
            .ENABLE_ITYPE (1'(g != 1)),
            .ENABLE_JAL   (1'(g != 1)),
            .MEM_WAIT     (1'(g != 2))
        ) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .opcode     (op[g]),
            .zero       (zero),
            .mem_ready  (rdy[g]),
            .mem_req    (mem_req),
            .mem_write  (mem_write),
            .ir_write   (ir_write),
            .adr_src    (adr_src),
            .pc_write   (pc_write),
            .reg_write  (reg_write),
            .alu_src_a  (alu_src_a),
            .alu_src_b  (alu_src_b),
            .result_src (result_src),
            .alu_op     (alu_op),
            .illegal    (illegal),
            .state      (state)
        );

        assign obs[g] = {state, mem_req, mem_write, ir_write, adr_src, pc_write, reg_write,
                         alu_src_a, alu_src_b, result_src, alu_op, illegal};
    end

    // Packs one expected output vector in the same field order as obs.
    function automatic logic [VW-1:0] v(input logic [3:0] st, input logic mreq, input logic mw,
                                        input logic irw, input logic adr, input logic pcw,
                                        input logic rw, input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] rs, input logic [1:0] aop, input logic ill);
        return {st, mreq, mw, irw, adr, pcw, rw, a, b, rs, aop, ill};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input int idx, input logic [VW-1:0] exp);
        #1;
        n_cmp++;
        assert (obs[idx] === exp)
        else begin
            n_err++;
            $error("FAIL %s dut%0d: observed %05h expected %05h", tag, idx, obs[idx], exp);
        end
    endtask

    logic [VW-1:0] FET, FETW, DEC, MADR, MRD, MWB, MWR, EXR, EXI, AWB, JALV, BEQ1, BEQ0, TRP;

    initial begin
        n_cmp = 0;
        n_err = 0;
        //          st  mq mw ir ad pc rw  a  b  rs op il
        FET  = v(4'd0,  1, 0, 1, 0, 1, 0, 0, 2, 2, 0, 0);
        FETW = v(4'd0,  1, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0);
        DEC  = v(4'd1,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        MADR = v(4'd2,  0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        MRD  = v(4'd3,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        MWB  = v(4'd4,  0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        MWR  = v(4'd5,  1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        EXR  = v(4'd6,  0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0);
        EXI  = v(4'd7,  0, 0, 0, 0, 0, 0, 2, 1, 0, 2, 0);
        AWB  = v(4'd8,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        JALV = v(4'd9,  0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0);
        BEQ1 = v(4'd10, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1, 0);
        BEQ0 = v(4'd10, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0);
        TRP  = v(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            op[i]  = 7'b0110011;
            rdy[i] = (i != 2);
        end

        // Reset: FETCH outputs with write enables gated even though ready is high.
        #2;
        look("reset_fetch", 0, FETW);
        look("reset_fetch_nowait", 2, FETW);
        cyc();
        look("reset_hold_edge", 0, FETW);

        // R-type with ready high.
        rst[0] = 1'b0;
        look("r_fetch", 0, FET);
        cyc(); look("r_decode", 0, DEC);
        cyc(); look("r_execr", 0, EXR);
        cyc(); look("r_aluwb", 0, AWB);
        cyc(); look("r_next_fetch", 0, FET);

        // Fetch stall, then I-type.
        op[0]  = 7'b0010011;
        rdy[0] = 1'b0;
        look("fetch_stall", 0, FETW);
        cyc(); look("fetch_stall_hold", 0, FETW);
        rdy[0] = 1'b1;
        look("fetch_ready", 0, FET);
        cyc(); look("i_decode", 0, DEC);
        cyc(); look("i_execi", 0, EXI);
        cyc(); look("i_aluwb", 0, AWB);
        cyc(); look("i_next_fetch", 0, FET);

        // Load with three wait cycles in MEMREAD.
        op[0] = 7'b0000011;
        cyc(); look("ld_decode", 0, DEC);
        cyc(); rdy[0] = 1'b0; look("ld_memadr", 0, MADR);
        cyc(); look("ld_memread_w1", 0, MRD);
        cyc(); look("ld_memread_w2", 0, MRD);
        cyc(); look("ld_memread_w3", 0, MRD);
        cyc(); rdy[0] = 1'b1; look("ld_memread_done", 0, MRD);
        cyc(); look("ld_memwb", 0, MWB);
        cyc(); look("ld_next_fetch", 0, FET);

        // Store with ready high.
        op[0] = 7'b0100011;
        cyc(); look("st_decode", 0, DEC);
        cyc(); look("st_memadr", 0, MADR);
        cyc(); look("st_memwrite", 0, MWR);
        cyc(); look("st_next_fetch", 0, FET);

        // BEQ taken then not taken.
        op[0] = 7'b1100011;
        zero  = 1'b1;
        cyc(); look("beq1_decode", 0, DEC);
        cyc(); look("beq_taken", 0, BEQ1);
        cyc(); look("beq1_next_fetch", 0, FET);
        zero = 1'b0;
        cyc(); look("beq0_decode", 0, DEC);
        cyc(); look("beq_not_taken", 0, BEQ0);
        cyc(); look("beq0_next_fetch", 0, FET);

        // JAL enabled.
        op[0] = 7'b1101111;
        cyc(); look("jal_decode", 0, DEC);
        cyc(); look("jal_state", 0, JALV);
        cyc(); look("jal_aluwb", 0, AWB);
        cyc(); look("jal_next_fetch", 0, FET);

        // Unknown opcode traps.
        op[0] = 7'b1111111;
        cyc(); look("bad_decode", 0, DEC);
        cyc(); look("bad_trap", 0, TRP);

        // Recover by reset, then async reset in the middle of a load.
        rst[0] = 1'b1;
        look("trap_reset", 0, FETW);
        cyc();
        rst[0] = 1'b0;
        op[0]  = 7'b0000011;
        look("ld2_fetch", 0, FET);
        cyc(); look("ld2_decode", 0, DEC);
        cyc(); rdy[0] = 1'b0; look("ld2_memadr", 0, MADR);
        cyc(); look("ld2_memread", 0, MRD);
        rst[0] = 1'b1;
        look("async_reset_midread", 0, FETW);
        rdy[0] = 1'b1;
        look("async_reset_gates_we", 0, FETW);
        cyc();
        rst[0] = 1'b0;
        op[0]  = 7'b0110011;
        look("post_reset_fetch", 0, FET);
        cyc(); look("post_reset_decode", 0, DEC);
        cyc(); look("post_reset_execr", 0, EXR);

        // JAL disabled: sticky trap.
        rst[1] = 1'b0;
        op[1]  = 7'b1101111;
        look("nj_fetch", 1, FET);
        cyc(); look("nj_decode", 1, DEC);
        cyc(); look("nj_trap", 1, TRP);
        for (int i = 0; i < 12; i++) begin
            cyc();
            rdy[1] = 1'(i % 2);
            op[1]  = 7'b0110011;
            look("nj_trap_sticky", 1, TRP);
        end
        rst[1] = 1'b1;
        look("nj_trap_cleared", 1, FETW);
        cyc();
        rst[1] = 1'b0;
        rdy[1] = 1'b1;
        op[1]  = 7'b0010011;
        look("ni_fetch", 1, FET);
        cyc(); look("ni_decode", 1, DEC);
        cyc(); look("ni_trap", 1, TRP);

        // No memory wait: store completes with mem_ready tied low.
        rst[2] = 1'b0;
        op[2]  = 7'b0100011;
        look("nw_fetch", 2, FET);
        cyc(); look("nw_decode", 2, DEC);
        cyc(); look("nw_memadr", 2, MADR);
        cyc(); look("nw_memwrite", 2, MWR);
        cyc(); look("nw_next_fetch", 2, FET);
        cyc(); look("nw_next_decode", 2, DEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle RISC-V control unit: a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles, replacing the single-cycle opcode decoder. It sits between the instruction register and the shared instruction/data memory, ALU and register file of the multicycle datapath. It drives all mux selects and write enables, and stalls on a memory-ready handshake. The I-type ALU and JAL paths are parameter-enabled; unsupported opcodes enter a sticky trap state.

## Interface
- ENABLE_ITYPE, 1: accept opcode 0010011 (ALU immediate); 0 treats it as illegal.
- ENABLE_JAL, 1: accept opcode 1101111; 0 treats it as illegal.
- MEM_WAIT, 1: honour mem_ready; 0 treats mem_ready as constant 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH.
- opcode  in  7  instruction[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- mem_req  out  1  memory access requested.
- mem_write  out  1  request is a store.
- ir_write  out  1  load the instruction register.
- adr_src  out  1  memory address: 0 = PC, 1 = ALU result register.
- pc_write  out  1  load the PC.
- reg_write  out  1  register file write.
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = register A.
- alu_src_b  out  2  00 = register B, 01 = immediate, 10 = constant 4.
- result_src  out  2  00 = ALU out register, 01 = data register, 10 = ALU result.
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- illegal  out  1  trap state active.
- state  out  4  current state encoding, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, TRAP.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - ir_write and pc_write assert only when mem_ready=1.
  - Goes to DECODE on mem_ready; otherwise holds.
- DECODE:
  - Outputs: a=01, b=01, alu_op=00 (branch target).
  - Next state by opcode:
    - 0000011 or 0100011 goes to MEMADR.
    - 0110011 goes to EXECR.
    - 0010011 goes to EXECI when enabled.
    - 1101111 goes to JAL when enabled.
    - 1100011 goes to BEQ.
    - Any other opcode goes to TRAP.
- MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD if opcode=0000011, otherwise MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Goes to MEMWB on mem_ready; otherwise holds.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Goes to FETCH on mem_ready; otherwise holds.
- EXECR: a=10, b=00, alu_op=10. Goes to ALUWB.
- EXECI: a=10, b=01, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1. Goes to FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB.
- BEQ:
  - Outputs: a=10, b=00, alu_op=01, result_src=00.
  - pc_write = zero (combinational from the zero input).
  - Goes to FETCH.
- TRAP: illegal=1, all enables 0; stays until reset.
- Any output not listed for a state is 0.
- Selects are don't-care where unused but driven to 0. No x is ever driven.

## Timing
- All outputs are a function of the state register only, except:
  - pc_write in BEQ depends on zero.
  - ir_write and pc_write in FETCH depend on mem_ready.
- Cycle counts with mem_ready held at 1:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - BEQ: 3 cycles.
  - JAL: 4 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- While waiting, mem_req and mem_write stay asserted and all selects hold.
- mem_ready outside the three memory states is ignored.
- Asynchronous reset:
  - state=FETCH immediately, mid-instruction included.
  - Outputs take FETCH values: mem_req=1, all write enables 0 while reset is high.
  - First fetch occurs on the first edge after reset deasserts.

## Structure
- Shared package ctrl_pkg holds:
  - the state enum (4-bit);
  - opcode localparams;
  - the alu_src_a, alu_src_b, result_src and alu_op encodings.
- One natural sub-module is alu_decoder (alu_op, funct3, funct7[5] → ALU control). It is instantiated beside this block, not inside it.

## Test plan
- Reset mid-MEMREAD → state=FETCH asynchronously, reg_write=0, and the next fetch proceeds normally.
- R-type 0110011, mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; reg_write high only in cycle 4; alu_op=10 in EXECR.
- Load 0000011 with mem_ready low for 3 cycles in MEMREAD → MEMREAD held for 4 cycles with adr_src=1; MEMWB follows with result_src=01.
- BEQ with zero=1, then with zero=0 → pc_write=1 and pc_write=0 respectively in the BEQ state; 3 cycles each.
- ENABLE_JAL=0, opcode 1101111 → TRAP, illegal=1 sticky for 10 or more cycles; cleared only by reset.
- Store with MEM_WAIT=0 and mem_ready tied 0 → mem_write=1 for exactly 1 cycle, then FETCH completes without stalling.
